// File: rtl/spike_gen_bank.sv
// rtl/spike_gen_bank.sv - programmable bank of periodic spike generators
//
// Holds {period, ticks, tag} for 2**Ngens generators, written over the
// prog_* channel while idle. Each time_unit_pulse starts a scan of entries
// 0..gens_used. An active entry either counts its ticks down or, at zero,
// reloads to period-1 and emits its tag downstream on out_*.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   time_unit_pulse     - one-cycle strobe per wall-clock time unit
//   gens_used, gens_en  - highest scanned index (inclusive), per-generator enable
//   prog_*              - programming channel (gen_idx, period, ticks, tag, v/a)
//   out_tag/out_ct/out_v/out_a - fired-spike word channel (out_ct is always 1)
//   overrun             - sticky: a pulse arrived during a scan
//   overrun_cnt         - saturating dropped-pulse count, only when
//                         SPIKE_GEN_OVERRUN_CNT_EN is defined
module spike_gen_bank #(
    parameter int Ngens   = 8,
    parameter int Nperiod = 16,
    parameter int Ntag    = 11,
    parameter int Nct     = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  time_unit_pulse,
    input  logic [Ngens-1:0]      gens_used,
    input  logic [2**Ngens-1:0]   gens_en,
    input  logic [Ngens-1:0]      prog_gen_idx,
    input  logic [Nperiod-1:0]    prog_period,
    input  logic [Nperiod-1:0]    prog_ticks,
    input  logic [Ntag-1:0]       prog_tag,
    input  logic                  prog_v,
    output logic                  prog_a,
    output logic [Ntag-1:0]       out_tag,
    output logic [Nct-1:0]        out_ct,
    output logic                  out_v,
    input  logic                  out_a,
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
    output logic [15:0]           overrun_cnt,
`endif
    output logic                  overrun
);

    localparam int DEPTH = 2**Ngens;
    localparam logic [Nperiod-1:0] ONE_P = Nperiod'(1);
    localparam logic [Ngens-1:0]   ONE_I = Ngens'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT
    } state_t;

    state_t               state_q, state_d;
    logic [Ngens-1:0]     idx_q, idx_d;
    logic                 out_v_q, out_v_d;
    logic [Ntag-1:0]      out_tag_q, out_tag_d;
    logic                 overrun_q, overrun_d;

    logic [Nperiod-1:0]   period_q [DEPTH];
    logic [Nperiod-1:0]   ticks_q  [DEPTH];
    logic [Ntag-1:0]      tag_q    [DEPTH];

    // Single write port shared by programming (idle) and tick updates (scan).
    logic                 wr_en;
    logic [Ngens-1:0]     wr_idx;
    logic [Nperiod-1:0]   wr_period;
    logic [Nperiod-1:0]   wr_ticks;
    logic [Ntag-1:0]      wr_tag;

    logic [Nperiod-1:0]   cur_period;
    logic [Nperiod-1:0]   cur_ticks;
    logic [Ntag-1:0]      cur_tag;
    logic                 active;
    logic                 last;
    logic                 pulse_drop;

    assign cur_period = period_q[idx_q];
    assign cur_ticks  = ticks_q[idx_q];
    assign cur_tag    = tag_q[idx_q];
    assign active     = gens_en[idx_q] && (cur_period != '0);
    // >= rather than == so that shrinking gens_used below idx mid-scan
    // still terminates the scan instead of wrapping the index.
    assign last       = (idx_q >= gens_used);
    assign pulse_drop = time_unit_pulse && (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        out_v_d   = out_v_q;
        out_tag_d = out_tag_q;
        overrun_d = overrun_q | pulse_drop;
        prog_a    = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = idx_q;
        wr_period = cur_period;
        wr_ticks  = cur_ticks;
        wr_tag    = cur_tag;

        case (state_q)
            S_IDLE: begin
                prog_a = !time_unit_pulse && !reset;
                if (time_unit_pulse) begin
                    idx_d   = '0;
                    state_d = S_SCAN;
                end else if (prog_v) begin
                    wr_en     = 1'b1;
                    wr_idx    = prog_gen_idx;
                    wr_period = prog_period;
                    wr_ticks  = prog_ticks;
                    wr_tag    = prog_tag;
                end
            end

            S_SCAN: begin
                if (active && (cur_ticks == '0)) begin
                    wr_en     = 1'b1;
                    wr_ticks  = cur_period - ONE_P;
                    out_tag_d = cur_tag;
                    out_v_d   = 1'b1;
                    state_d   = S_EMIT;
                end else begin
                    if (active) begin
                        wr_en    = 1'b1;
                        wr_ticks = cur_ticks - ONE_P;
                    end
                    if (last) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + ONE_I;
                    end
                end
            end

            S_EMIT: begin
                if (out_a) begin
                    out_v_d = 1'b0;
                    if (last) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + ONE_I;
                        state_d = S_SCAN;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            out_v_q   <= 1'b0;
            out_tag_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            out_v_q   <= out_v_d;
            out_tag_q <= out_tag_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                period_q[i] <= '0;
                ticks_q[i]  <= '0;
                tag_q[i]    <= '0;
            end
        end else if (wr_en) begin
            period_q[wr_idx] <= wr_period;
            ticks_q[wr_idx]  <= wr_ticks;
            tag_q[wr_idx]    <= wr_tag;
        end
    end

`ifdef SPIKE_GEN_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt_q, overrun_cnt_d;

    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (pulse_drop && (overrun_cnt_q != 16'hFFFF)) begin
            overrun_cnt_d = overrun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt_q <= '0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

    assign out_v   = out_v_q;
    assign out_tag = out_tag_q;
    assign out_ct  = Nct'(1);
    assign overrun = overrun_q;

endmodule
